dmem_responder: RTL and testbench

- Memory-side responder for the data memory interface driven by the multicycle control unit and datapath.
- Accepts one load/store request per handshake and commits stores with byte-lane splicing.
- Returns load data extracted and extended per access size after a fixed, parameterised latency.
- Replaces the bare 1-cycle memory model, so the FSM wait states can be exercised against real handshaking and error responses.

---
 rtl/dmem_responder_pkg.sv | 44 ++++
 rtl/dmem_responder_if.sv | 24 ++
 rtl/mem_lane_splice.sv | 44 ++++
 rtl/dmem_responder.sv | 105 ++++++++++
 tb/tb_dmem_responder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared memory-access types: access sizes, datapath splice codes and their mapping.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_D = 2'd0,
        SZ_W = 2'd1,
        SZ_H = 2'd2,
        SZ_B = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        SPL_LD  = 3'd0,
        SPL_LW  = 3'd1,
        SPL_LH  = 3'd2,
        SPL_LBU = 3'd3,
        SPL_SD  = 3'd4,
        SPL_SW  = 3'd5,
        SPL_SH  = 3'd6,
        SPL_SB  = 3'd7
    } spl_t;

    function automatic mem_size_t spl_to_size(spl_t s);
        case (s)
            SPL_LD, SPL_SD: return SZ_D;
            SPL_LW, SPL_SW: return SZ_W;
            SPL_LH, SPL_SH: return SZ_H;
            default:        return SZ_B;
        endcase
    endfunction

    function automatic logic spl_is_store(spl_t s);
        return s inside {SPL_SD, SPL_SW, SPL_SH, SPL_SB};
    endfunction

    function automatic logic misaligned(mem_size_t sz, logic [2:0] lo);
        case (sz)
            SZ_D:    return lo != 3'd0;
            SZ_W:    return lo[1:0] != 2'd0;
            SZ_H:    return lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the data-memory requester and the responder.
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [63:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/mem_lane_splice.sv
// Combinational byte-lane splice: store byte enables/positioned data, load extract/extend.
// Zero latency; no flow control.
module mem_lane_splice
    import dmem_responder_pkg::*;
(
    input  mem_size_t   size_i,
    input  logic [2:0]  offs_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rdata_i,
    output logic [7:0]  be_o,
    output logic [63:0] wdata_o,
    output logic [63:0] rdata_o
);
    logic [31:0] word_v;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        word_v  = rdata_i[{offs_i[2], 5'b0} +: 32];
        half_v  = rdata_i[{offs_i[2:1], 4'b0} +: 16];
        byte_v  = rdata_i[{offs_i, 3'b0} +: 8];
        be_o    = 8'hFF;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SZ_D: ;
            SZ_W: begin
                be_o    = offs_i[2] ? 8'hF0 : 8'h0F;
                wdata_o = {2{wdata_i[31:0]}};
                rdata_o = {{32{word_v[31]}}, word_v};
            end
            SZ_H: begin
                be_o    = 8'h03 << {offs_i[2:1], 1'b0};
                wdata_o = {4{wdata_i[15:0]}};
                rdata_o = {{48{half_v[15]}}, half_v};
            end
            default: begin
                be_o    = 8'h01 << offs_i;
                wdata_o = {8{wdata_i[7:0]}};
                rdata_o = {56'd0, byte_v};
            end
        endcase
    end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response LATENCY cycles after acceptance.
// req_ready drops while waiting; stores commit on the edge after acceptance.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_DW = 256,
    parameter int ADDR_W   = 32,
    parameter int LATENCY  = 1
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave dmem
);
    localparam int               IDX_W      = $clog2(DEPTH_DW);
    localparam int               AQ_W       = IDX_W + 3;
    localparam logic [ADDR_W:0]  ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_DW * 8);
    localparam logic [3:0]       CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            commit_q;
    logic            we_q, err_q;
    mem_size_t       size_q;
    logic [AQ_W-1:0] addr_q;
    logic [63:0]     wdata_q;

    logic [63:0]     mem [DEPTH_DW];

    logic            accept, req_err;
    mem_size_t       req_sz;
    logic [7:0]      be;
    logic [63:0]     wpos, rd_dw, rd_ext;

    assign req_sz  = mem_size_t'(dmem.req_size);
    assign req_err = misaligned(req_sz, dmem.req_addr[2:0]) ||
                     ({1'b0, dmem.req_addr} >= ADDR_LIMIT);

    assign dmem.req_ready = (state_q != S_WAIT);
    assign accept         = dmem.req_valid && dmem.req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_WAIT) begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
        end else if (accept) begin
            state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
            cnt_d   = CNT_INIT;
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            commit_q <= accept && dmem.req_we && !req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= dmem.req_we;
            err_q   <= req_err;
            size_q  <= req_sz;
            addr_q  <= dmem.req_addr[AQ_W-1:0];
            wdata_q <= dmem.req_wdata;
        end
    end

    // Captured fields still hold the store on its commit edge, even if a new request lands then.
    always_ff @(posedge clk) begin
        if (commit_q && !reset) begin
            for (int i = 0; i < 8; i++) begin
                if (be[i]) mem[addr_q[AQ_W-1:3]][8*i +: 8] <= wpos[8*i +: 8];
            end
        end
    end

    assign rd_dw = mem[addr_q[AQ_W-1:3]];

    mem_lane_splice u_splice (
        .size_i  (size_q),
        .offs_i  (addr_q[2:0]),
        .wdata_i (wdata_q),
        .rdata_i (rd_dw),
        .be_o    (be),
        .wdata_o (wpos),
        .rdata_o (rd_ext)
    );

    assign dmem.resp_valid = (state_q == S_RESP);
    assign dmem.resp_err   = dmem.resp_valid && err_q;
    assign dmem.resp_rdata = (dmem.resp_valid && !err_q && !we_q) ? rd_ext : 64'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at LATENCY 1 and 3 against a byte-array reference model.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        t_valid = 1'b0;
    logic        t_we = 1'b0;
    logic [1:0]  t_size = 2'd0;
    logic [31:0] t_addr = 32'd0;
    logic [63:0] t_wdata = 64'd0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32)) b1 ();
    dmem_responder_if #(.ADDR_W(32)) b3 ();

    assign b1.req_valid = t_valid && !sel;
    assign b3.req_valid = t_valid && sel;
    assign b1.req_we    = t_we;
    assign b3.req_we    = t_we;
    assign b1.req_size  = t_size;
    assign b3.req_size  = t_size;
    assign b1.req_addr  = t_addr;
    assign b3.req_addr  = t_addr;
    assign b1.req_wdata = t_wdata;
    assign b3.req_wdata = t_wdata;

    logic        ready_m, rv_m, err_m;
    logic [63:0] rd_m;
    assign ready_m = sel ? b3.req_ready  : b1.req_ready;
    assign rv_m    = sel ? b3.resp_valid : b1.resp_valid;
    assign err_m   = sel ? b3.resp_err   : b1.resp_err;
    assign rd_m    = sel ? b3.resp_rdata : b1.resp_rdata;

    dmem_responder #(.DEPTH_DW(256), .ADDR_W(32), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .dmem(b1));
    dmem_responder #(.DEPTH_DW(256), .ADDR_W(32), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .dmem(b3));

    // Reference memory: plain bytes per DUT, little-endian.
    logic [7:0] mdl [2][2048];

    function automatic int nbytes(input logic [1:0] sz);
        return 8 >> sz;
    endfunction

    task automatic model_access(input int d, input logic we, input logic [1:0] sz,
                                input logic [31:0] a, input logic [63:0] wd,
                                output logic e, output logic [63:0] r);
        int n;
        logic [63:0] v;
        n = nbytes(sz);
        e = (a >= 32'd2048) || ((a % n) != 0);
        r = 64'd0;
        if (!e) begin
            if (we) begin
                for (int i = 0; i < n; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[d][int'(a) + i];
                if (sz != 2'd3 && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
                r = v;
            end
        end
    endtask

    task automatic xact(input logic s, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [63:0] wd,
                        output logic e, output logic [63:0] r, output int lat);
        int guard;
        @(negedge clk);
        sel = s; t_we = we; t_size = sz; t_addr = a; t_wdata = wd; t_valid = 1'b1;
        guard = 0;
        while (!ready_m && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        t_valid = 1'b0;
        lat = 1;
        while (!rv_m && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        e = err_m;
        r = rd_m;
    endtask

    task automatic gen_req(input logic [31:0] pa);
        int r;
        logic [31:0] a;
        r       = $urandom_range(0, 7);
        t_we    = 1'($urandom_range(0, 1));
        t_size  = 2'($urandom_range(0, 3));
        t_wdata = {$urandom, $urandom};
        a = 32'($urandom_range(0, 511));
        if (r != 7) a = a & ~(32'(nbytes(t_size)) - 32'd1);
        if (r == 0)     a = 32'd2048 + 32'($urandom_range(0, 8191));
        else if (r < 3) a = pa;
        t_addr = a;
    endtask

    task automatic test_reset();
        checks++; if (b1.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_l1 got=%b exp=1", b1.req_ready); end
        checks++; if (b3.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_l3 got=%b exp=1", b3.req_ready); end
        checks++; if (b1.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid_l1 got=%b exp=0", b1.resp_valid); end
        checks++; if (b3.resp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid_l3 got=%b exp=0", b3.resp_valid); end
        checks++; if (b1.resp_err !== 1'b0) begin failures++; $display("FAIL rst_err_l1 got=%b exp=0", b1.resp_err); end
        checks++; if (b3.resp_err !== 1'b0) begin failures++; $display("FAIL rst_err_l3 got=%b exp=0", b3.resp_err); end
        checks++; if (b1.resp_rdata !== 64'd0) begin failures++; $display("FAIL rst_rdata_l1 got=%h exp=0", b1.resp_rdata); end
        checks++; if (b3.resp_rdata !== 64'd0) begin failures++; $display("FAIL rst_rdata_l3 got=%h exp=0", b3.resp_rdata); end
    endtask

    task automatic test_init();
        logic e;
        logic [63:0] r, wd;
        int lat;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) begin
                wd = {$urandom, $urandom};
                model_access(d, 1'b1, 2'd0, 32'(i * 8), wd, e, r);
                xact(1'(d), 1'b1, 2'd0, 32'(i * 8), wd, e, r, lat);
            end
        end
    endtask

    task automatic test_directed();
        logic e, me;
        logic [63:0] r, mr;
        int lat;
        model_access(0, 1'b1, 2'd0, 32'h10, 64'h1122334455667788, me, mr);
        xact(1'b0, 1'b1, 2'd0, 32'h10, 64'h1122334455667788, e, r, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL sd_lat got=%0d exp=1", lat); end
        checks++; if (e !== 1'b0 || r !== 64'd0) begin failures++; $display("FAIL sd_resp got=%b/%h exp=0/0", e, r); end
        model_access(0, 1'b0, 2'd0, 32'h10, 64'd0, me, mr);
        xact(1'b0, 1'b0, 2'd0, 32'h10, 64'd0, e, r, lat);
        checks++; if (r !== 64'h1122334455667788 || e !== 1'b0) begin failures++; $display("FAIL ld_d got=%b/%h exp=0/1122334455667788", e, r); end
        checks++; if (lat !== 1) begin failures++; $display("FAIL ld_lat got=%0d exp=1", lat); end
        model_access(0, 1'b1, 2'd3, 32'h13, 64'hAB, me, mr);
        xact(1'b0, 1'b1, 2'd3, 32'h13, 64'hAB, e, r, lat);
        model_access(0, 1'b0, 2'd3, 32'h13, 64'd0, me, mr);
        xact(1'b0, 1'b0, 2'd3, 32'h13, 64'd0, e, r, lat);
        checks++; if (r !== 64'hAB) begin failures++; $display("FAIL lbu got=%h exp=ab", r); end
        model_access(0, 1'b0, 2'd1, 32'h10, 64'd0, me, mr);
        xact(1'b0, 1'b0, 2'd1, 32'h10, 64'd0, e, r, lat);
        checks++; if (r !== 64'hFFFFFFFFAB667788) begin failures++; $display("FAIL lw_sext got=%h exp=ffffffffab667788", r); end
        model_access(0, 1'b1, 2'd0, 32'h10, 64'h8000123456789ABC, me, mr);
        xact(1'b0, 1'b1, 2'd0, 32'h10, 64'h8000123456789ABC, e, r, lat);
        model_access(0, 1'b0, 2'd2, 32'h16, 64'd0, me, mr);
        xact(1'b0, 1'b0, 2'd2, 32'h16, 64'd0, e, r, lat);
        checks++; if (r !== 64'hFFFFFFFFFFFF8000) begin failures++; $display("FAIL lh_sext got=%h exp=ffffffffffff8000", r); end
        model_access(0, 1'b1, 2'd0, 32'h10, 64'h7FFFFFFFDEADBEEF, me, mr);
        xact(1'b0, 1'b1, 2'd0, 32'h10, 64'h7FFFFFFFDEADBEEF, e, r, lat);
        model_access(0, 1'b0, 2'd1, 32'h14, 64'd0, me, mr);
        xact(1'b0, 1'b0, 2'd1, 32'h14, 64'd0, e, r, lat);
        checks++; if (r !== 64'h000000007FFFFFFF) begin failures++; $display("FAIL lw_pos got=%h exp=000000007fffffff", r); end
    endtask

    task automatic test_latency3();
        logic ea, eb;
        logic [63:0] ra, rb;
        int exp_rdy[7] = '{0, 0, 1, 0, 0, 1, 1};
        int exp_rv[7]  = '{0, 0, 1, 0, 0, 1, 0};
        logic [63:0] rd[7];
        logic rdy[7], rv[7];
        model_access(1, 1'b0, 2'd0, 32'h10, 64'd0, ea, ra);
        model_access(1, 1'b0, 2'd0, 32'h18, 64'd0, eb, rb);
        @(negedge clk);
        sel = 1'b1; t_we = 1'b0; t_size = 2'd0; t_addr = 32'h10; t_valid = 1'b1;
        checks++; if (ready_m !== 1'b1) begin failures++; $display("FAIL l3_idle_ready got=%b exp=1", ready_m); end
        @(negedge clk);
        t_addr = 32'h18;
        for (int c = 0; c < 7; c++) begin
            rdy[c] = ready_m; rv[c] = rv_m; rd[c] = rd_m;
            if (c == 3) t_valid = 1'b0;
            @(negedge clk);
        end
        for (int c = 0; c < 7; c++) begin
            checks++; if (rdy[c] !== 1'(exp_rdy[c])) begin failures++; $display("FAIL l3_ready c%0d got=%b exp=%0d", c + 1, rdy[c], exp_rdy[c]); end
            checks++; if (rv[c] !== 1'(exp_rv[c])) begin failures++; $display("FAIL l3_valid c%0d got=%b exp=%0d", c + 1, rv[c], exp_rv[c]); end
        end
        checks++; if (rd[2] !== ra) begin failures++; $display("FAIL l3_rdata_a got=%h exp=%h", rd[2], ra); end
        checks++; if (rd[5] !== rb) begin failures++; $display("FAIL l3_rdata_b got=%h exp=%h", rd[5], rb); end
    endtask

    task automatic test_errors(input int d, input int L);
        logic e, me;
        logic [63:0] r, mr;
        int lat;
        logic        we_t[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0]  sz_t[3] = '{2'd1, 2'd0, 2'd0};
        logic [31:0] a_t[3]  = '{32'h2, 32'h4, 32'd2048};
        for (int k = 0; k < 3; k++) begin
            model_access(d, we_t[k], sz_t[k], a_t[k], {$urandom, $urandom}, me, mr);
            xact(1'(d), we_t[k], sz_t[k], a_t[k], 64'hFFFF_FFFF_FFFF_FFFF, e, r, lat);
            checks++; if (e !== me || e !== 1'b1) begin failures++; $display("FAIL err_flag d%0d k%0d got=%b exp=%b", d, k, e, me); end
            checks++; if (r !== 64'd0) begin failures++; $display("FAIL err_rdata d%0d k%0d got=%h exp=0", d, k, r); end
            checks++; if (lat !== L) begin failures++; $display("FAIL err_lat d%0d k%0d got=%0d exp=%0d", d, k, lat, L); end
        end
        model_access(d, 1'b0, 2'd0, 32'h0, 64'd0, me, mr);
        xact(1'(d), 1'b0, 2'd0, 32'h0, 64'd0, e, r, lat);
        checks++; if (r !== mr || e !== 1'b0) begin failures++; $display("FAIL err_nowrite d%0d got=%b/%h exp=0/%h", d, e, r, mr); end
    endtask

    task automatic test_reset_midop();
        logic e, me;
        logic [63:0] r, mr;
        int lat;
        @(negedge clk);
        sel = 1'b1; t_we = 1'b1; t_size = 2'd0; t_addr = 32'h20; t_wdata = 64'hDEAD_0000_BEEF_0000; t_valid = 1'b1;
        @(negedge clk);
        t_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (ready_m !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", ready_m); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (rv_m !== 1'b0) begin failures++; $display("FAIL midrst_novalid c%0d got=%b exp=0", c, rv_m); end
            @(negedge clk);
        end
        model_access(1, 1'b0, 2'd0, 32'h20, 64'd0, me, mr);
        xact(1'b1, 1'b0, 2'd0, 32'h20, 64'd0, e, r, lat);
        checks++; if (r !== mr) begin failures++; $display("FAIL midrst_dropped got=%h exp=%h", r, mr); end
    endtask

    task automatic test_back_to_back(input int d, input int n, input int L);
        logic        e_q[$];
        logic [63:0] r_q[$];
        int          c_q[$];
        logic        e;
        logic [63:0] r;
        int issued, got, cyc, exp_c;
        bit acc;
        issued = 0; got = 0; cyc = 0;
        @(negedge clk);
        sel = 1'(d);
        gen_req(32'h10);
        t_valid = 1'b1;
        while (got < n && cyc < 3000) begin
            if (rv_m) begin
                if (c_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b2b_spurious d%0d cyc=%0d got=1 exp=0", d, cyc);
                end else begin
                    exp_c = c_q.pop_front(); e = e_q.pop_front(); r = r_q.pop_front();
                    checks++; if (cyc !== exp_c) begin failures++; $display("FAIL b2b_cycle d%0d got=%0d exp=%0d", d, cyc, exp_c); end
                    checks++; if (err_m !== e) begin failures++; $display("FAIL b2b_err d%0d cyc=%0d got=%b exp=%b", d, cyc, err_m, e); end
                    checks++; if (rd_m !== r) begin failures++; $display("FAIL b2b_rdata d%0d cyc=%0d got=%h exp=%h", d, cyc, rd_m, r); end
                end
                got++;
            end else begin
                checks++;
                if (err_m !== 1'b0 || rd_m !== 64'd0) begin
                    failures++; $display("FAIL b2b_idle_zero d%0d cyc=%0d got=%b/%h exp=0/0", d, cyc, err_m, rd_m);
                end
            end
            acc = t_valid && ready_m;
            if (acc) begin
                model_access(d, t_we, t_size, t_addr, t_wdata, e, r);
                e_q.push_back(e); r_q.push_back(r); c_q.push_back(cyc + L);
                issued++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (issued < n) gen_req(t_addr);
                else            t_valid = 1'b0;
            end
        end
        t_valid = 1'b0;
        checks++; if (got !== n) begin failures++; $display("FAIL b2b_timeout d%0d got=%0d exp=%0d", d, got, n); end
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_init();
        test_directed();
        test_latency3();
        test_errors(0, 1);
        test_errors(1, 3);
        test_reset_midop();
        test_back_to_back(0, 60, 1);
        test_back_to_back(1, 40, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
